// File: rtl/riscv_hazard_unit.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load/branch/RAW
// stalls, multi-cycle EX stall FSM and saturating stall/flush counters.
module riscv_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] i_rs1_D,
  input  logic [REG_ADDR_W-1:0] i_rs2_D,
  input  logic                  i_branch_D,
  input  logic                  i_take_branch_D,
  input  logic [REG_ADDR_W-1:0] i_rs1_E,
  input  logic [REG_ADDR_W-1:0] i_rs2_E,
  input  logic [REG_ADDR_W-1:0] i_rd_E,
  input  logic                  i_wr_en_E,
  input  logic                  i_sel_result_E,
  input  logic                  i_multicycle_E,
  input  logic [REG_ADDR_W-1:0] i_rd_M,
  input  logic                  i_wr_en_M,
  input  logic                  i_sel_result_M,
  input  logic [REG_ADDR_W-1:0] i_rd_W,
  input  logic                  i_wr_en_W,
  output logic                  o_en_F,
  output logic                  o_en_D,
  output logic                  o_en_E,
  output logic                  o_flush_D,
  output logic                  o_flush_E,
  output logic                  o_flush_M,
  output logic                  o_fwdA_D,
  output logic                  o_fwdB_D,
  output logic [1:0]            o_fwdA_E,
  output logic [1:0]            o_fwdB_E,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  localparam int unsigned     LAT_W    = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = (MULDIV_LAT > 2) ? LAT_W'(MULDIV_LAT - 2) : '0;
  localparam logic            MC_EN    = (MULDIV_LAT > 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lw_stall, br_stall, raw_stall, d_stall, mc_stall;
  logic hit_d_e, hit_d_m;

  function automatic logic match(input logic [REG_ADDR_W-1:0] a, input logic [REG_ADDR_W-1:0] r);
    return (a != '0) && (a == r);
  endfunction

  // M has the younger value, so it takes priority over W.
  function automatic logic [1:0] fwd_e(input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rd_m, input logic we_m,
                                       input logic [REG_ADDR_W-1:0] rd_w, input logic we_w);
    if (we_m && match(rs, rd_m))      return 2'b10;
    else if (we_w && match(rs, rd_w)) return 2'b01;
    else                              return 2'b00;
  endfunction

  always_comb begin
    hit_d_e   = match(i_rs1_D, i_rd_E) || match(i_rs2_D, i_rd_E);
    hit_d_m   = match(i_rs1_D, i_rd_M) || match(i_rs2_D, i_rd_M);
    lw_stall  = i_sel_result_E && i_wr_en_E && hit_d_e;
    br_stall  = i_branch_D && ((i_wr_en_E && hit_d_e) ||
                               (i_wr_en_M && i_sel_result_M && hit_d_m));
    raw_stall = (i_wr_en_E && hit_d_e) || (i_wr_en_M && hit_d_m);
    mc_stall  = MC_EN && i_multicycle_E && !(state_q == BUSY && cnt_q == '0);

    if (FWD_EN != 0) begin
      d_stall  = lw_stall || br_stall;
      o_fwdA_D = i_wr_en_M && !i_sel_result_M && match(i_rs1_D, i_rd_M);
      o_fwdB_D = i_wr_en_M && !i_sel_result_M && match(i_rs2_D, i_rd_M);
      o_fwdA_E = fwd_e(i_rs1_E, i_rd_M, i_wr_en_M, i_rd_W, i_wr_en_W);
      o_fwdB_E = fwd_e(i_rs2_E, i_rd_M, i_wr_en_M, i_rd_W, i_wr_en_W);
    end else begin
      d_stall  = raw_stall;
      o_fwdA_D = 1'b0;
      o_fwdB_D = 1'b0;
      o_fwdA_E = 2'b00;
      o_fwdB_E = 2'b00;
    end

    // A multi-cycle stall freezes F/D/E and bubbles M, masking any D-stage hazard.
    o_en_F    = !(mc_stall || d_stall);
    o_en_D    = !(mc_stall || d_stall);
    o_en_E    = !mc_stall;
    o_flush_E = !mc_stall && d_stall;
    o_flush_M = mc_stall;
    o_flush_D = i_take_branch_D && !d_stall && !mc_stall;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (MC_EN && i_multicycle_E) begin
        state_d = BUSY;
        cnt_d   = LAT_INIT;
      end
      BUSY: if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!o_en_F && stall_cnt_q != '1)   stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (o_flush_D && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_busy      = (state_q == BUSY);
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule
